mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single unified multi-cycle memory between the instruction-cache miss handler and the data-cache miss/write-through handler of the pipelined 16-bit CPU.
- Grants one requester at a time.
- Issues either an 8-word burst line fill or a single-word write to memory, and steers returning words to the granted cache with a word index.
- Sits between the two cache controllers and the memory model.

Parameters:
- LINE_WORDS, 8, words per cache line; power of 2.
- IDX_W, 3, log2(LINE_WORDS); width of the fill word index.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  I-cache line-fill request; held high until i_done.
- i_addr  input  16  I-miss byte address; low 4 bits ignored.
- i_fill_valid  output  1  fill_data is a word for the I-cache.
- i_done  output  1  one-cycle pulse: I-fill complete.
- d_req  input  1  D-cache request; held high until d_done.
- d_wr  input  1  1 = single-word write, 0 = line fill; sampled with d_req.
- d_addr  input  16  D byte address; low 4 bits ignored for a fill, bit 0 ignored for a write.
- d_wdata  input  16  write data.
- d_fill_valid  output  1  fill_data is a word for the D-cache.
- d_done  output  1  one-cycle pulse: D op complete.
- fill_data  output  16  returning word; equals mem_rdata.
- fill_idx  output  IDX_W  index of the returning word within the line.
- busy  output  1  state != IDLE.
- mem_en  output  1  memory access this cycle.
- mem_wr  output  1  write qualifier.
- mem_addr  output  16  memory byte address.
- mem_wdata  output  16  write data to memory.
- mem_rdata  input  16  read data from memory.
- mem_rvalid  input  1  mem_rdata valid; pipelined, returned in issue order.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; issue_cnt and recv_cnt = 0.
  - All outputs 0, including mem_en, mem_wr, mem_addr, both done pulses and both fill_valid outputs.
  - Reset mid-operation abandons the transfer. No done is pulsed; the requester re-requests.
- States: IDLE, IFILL, DFILL, DWRITE, DONE.
- IDLE:
  - Samples requests. If d_req=1, go to DWRITE when d_wr=1, else DFILL. Otherwise, if i_req=1, go to IFILL.
  - D has fixed priority when d_req and i_req arrive in the same cycle.
  - Latches base = addr & 16'hFFF0 for a fill; latches {d_addr[15:1],1'b0} and d_wdata for a write.
  - No memory activity in the grant cycle. The first mem_en is in the cycle after.
- IFILL/DFILL, issue side:
  - For issue_cnt = 0..LINE_WORDS-1 on consecutive cycles: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - Address is computed mod 2^16, so the line at 0xFFF0 wraps cleanly.
  - After the last issue, mem_en=0.
- IFILL/DFILL, return side:
  - Each cycle with mem_rvalid=1: fill_data = mem_rdata, fill_idx = recv_cnt, and the granted *_fill_valid = 1 (combinational from mem_rvalid and state). recv_cnt then increments.
  - On the cycle the LINE_WORDS-th word returns, the granted *_done = 1 in that same cycle; next state is DONE.
- DWRITE: one cycle with mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latches; d_done = 1 in that cycle; next state is DONE.
- DONE: one idle cycle, requests ignored; next state IDLE. This lets the requester drop req after done, so a stale req is never re-granted.
- Fill latency: done arrives LAT+LINE_WORDS cycles after the grant edge, where LAT is the memory read latency.
- mem_rvalid in IDLE, DWRITE or DONE is ignored: no fill_valid is produced and no counter changes.
- Requests changing while not in IDLE are ignored.
- Counters are IDX_W+1 bits wide and are cleared on entry to IFILL/DFILL.

Test Plan:
- I-fill alone, LAT=4, i_addr=0x1234:
  - mem_addr = 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - i_fill_valid on 8 cycles with fill_idx 0..7.
  - i_done in the same cycle as idx 7, 12 cycles after the grant edge.
  - d_fill_valid stays 0 throughout.
- i_req and d_req (d_wr=0) high in the same cycle:
  - DFILL is served first; d_done pulses.
  - After the DONE cycle, IFILL starts with the I address latched then.
- D write, d_addr=0x0041, d_wdata=0xBEEF:
  - Exactly one cycle with mem_en=1, mem_wr=1, addr 0x0040, wdata 0xBEEF.
  - d_done in that same cycle.
  - busy is high for 2 cycles (DWRITE then DONE).
- Wrap: d fill at 0xFFF8: addresses 0xFFF0..0xFFFE; no carry into a wrong line.
- Reset mid-fill:
  - Assert rst_n=0 after the 3rd return word: all outputs 0 immediately.
  - Late mem_rvalid pulses after release produce no fill_valid; the next i_req starts a fresh fill at idx 0.
- Back-to-back I requests:
  - i_req held through i_done and re-asserted after a 1-cycle drop.
  - The second fill's grant occurs at the earliest in the cycle after DONE; no double grant occurs.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_arbiter.
// The arbiter takes the master view; caches and memory take the slave view.
interface mem_arbiter_if #(
  parameter int IDX_W = 3
);
  logic             i_req;
  logic [15:0]      i_addr;
  logic             i_fill_valid;
  logic             i_done;
  logic             d_req;
  logic             d_wr;
  logic [15:0]      d_addr;
  logic [15:0]      d_wdata;
  logic             d_fill_valid;
  logic             d_done;
  logic [15:0]      fill_data;
  logic [IDX_W-1:0] fill_idx;
  logic             busy;
  logic             mem_en;
  logic             mem_wr;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_rvalid;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_wr, d_addr, d_wdata,
    input  mem_rdata, mem_rvalid,
    output i_fill_valid, i_done,
    output d_fill_valid, d_done,
    output fill_data, fill_idx, busy,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_wr, d_addr, d_wdata,
    output mem_rdata, mem_rvalid,
    input  i_fill_valid, i_done,
    input  d_fill_valid, d_done,
    input  fill_data, fill_idx, busy,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between the I-cache and D-cache handlers:
// burst line fills for either side, single-word writes for the D side.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFILL,
    S_DFILL,
    S_DWRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [15:0]      base_q, base_d;
  logic [15:0]      wdata_q, wdata_d;

  logic             i_fv, d_fv;
  logic             i_dn, d_dn;
  logic             en, wr;
  logic [15:0]      addr, wdat, fdata;
  logic [IDX_W-1:0] fidx;

  // State, counters and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
    end
  end

  // Grant, issue/return sequencing and all outputs.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    i_fv    = 1'b0;
    d_fv    = 1'b0;
    i_dn    = 1'b0;
    d_dn    = 1'b0;
    en      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdat    = '0;
    fdata   = '0;
    fidx    = '0;
    unique case (state_q)
      S_IDLE: begin
        issue_d = '0;
        recv_d  = '0;
        if (bus.d_req) begin
          wdata_d = bus.d_wdata;
          if (bus.d_wr) begin
            state_d = S_DWRITE;
            base_d  = {bus.d_addr[15:1], 1'b0};
          end else begin
            state_d = S_DFILL;
            base_d  = bus.d_addr & 16'hFFF0;
          end
        end else if (bus.i_req) begin
          state_d = S_IFILL;
          base_d  = bus.i_addr & 16'hFFF0;
        end
      end
      S_IFILL, S_DFILL: begin
        if (issue_q < NWORDS) begin
          en      = 1'b1;
          addr    = base_q + 16'({issue_q, 1'b0});
          issue_d = issue_q + ONE;
        end
        if (bus.mem_rvalid) begin
          fidx   = recv_q[IDX_W-1:0];
          fdata  = bus.mem_rdata;
          recv_d = recv_q + ONE;
          if (state_q == S_IFILL) begin
            i_fv = 1'b1;
          end else begin
            d_fv = 1'b1;
          end
          if (recv_q == LAST) begin
            state_d = S_DONE;
            if (state_q == S_IFILL) begin
              i_dn = 1'b1;
            end else begin
              d_dn = 1'b1;
            end
          end
        end
      end
      S_DWRITE: begin
        en      = 1'b1;
        wr      = 1'b1;
        addr    = base_q;
        wdat    = wdata_q;
        d_dn    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.i_fill_valid = i_fv;
  assign bus.d_fill_valid = d_fv;
  assign bus.i_done       = i_dn;
  assign bus.d_done       = d_dn;
  assign bus.fill_data    = fdata;
  assign bus.fill_idx     = fidx;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.mem_en       = en;
  assign bus.mem_wr       = wr;
  assign bus.mem_addr     = addr;
  assign bus.mem_wdata    = wdat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a pipelined memory
// model and a timing-arithmetic reference of each granted operation.
module tb_mem_arbiter;

  localparam int LW = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.IDX_W(IW)) bus ();

  mem_arbiter #(
    .LINE_WORDS(LW),
    .IDX_W     (IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // memory: a read issued in cycle c returns in cycle c+lat
  int          lat = 4;
  logic        pv [16] = '{default: 1'b0};
  logic [15:0] pa [16];

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    for (int k = 15; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
    pv[0] <= bus.mem_en && !bus.mem_wr;
    pa[0] <= bus.mem_addr;
  end

  assign bus.mem_rvalid = pv[lat-1];
  assign bus.mem_rdata  = pv[lat-1] ? mem_f(pa[lat-1]) : 16'h0;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: one granted op at a time, described by kind/grant/end
  int          n = 0;
  int          m_kind = 0;
  int          m_g = 0;
  int          m_free = 0;
  logic [15:0] m_base = '0;
  logic [15:0] m_wd = '0;

  task automatic model_check();
    int t, idx;
    logic e_en, e_wr, e_ifv, e_dfv, e_idn, e_ddn, e_busy;
    logic [15:0] e_addr, e_wd, e_fd;
    e_en = 0; e_wr = 0; e_ifv = 0; e_dfv = 0;
    e_idn = 0; e_ddn = 0; e_busy = 0;
    e_addr = '0; e_wd = '0; e_fd = '0; idx = 0;
    if (n < m_free) begin
      e_busy = 1;
      t = n - m_g;
      if (m_kind == 3) begin
        if (t == 0) begin
          e_en = 1; e_wr = 1; e_ddn = 1;
          e_addr = m_base; e_wd = m_wd;
        end
      end else begin
        if (t < LW) begin
          e_en = 1;
          e_addr = m_base + 16'(2 * t);
        end
        if (t >= lat && t < lat + LW) begin
          idx = t - lat;
          e_fd = mem_f(m_base + 16'(2 * idx));
          if (m_kind == 1) e_ifv = 1;
          else e_dfv = 1;
          if (idx == LW - 1) begin
            if (m_kind == 1) e_idn = 1;
            else e_ddn = 1;
          end
        end
      end
    end else if (bus.d_req) begin
      m_g = n + 1;
      m_wd = bus.d_wdata;
      if (bus.d_wr) begin
        m_kind = 3;
        m_base = bus.d_addr & 16'hFFFE;
        m_free = m_g + 2;
      end else begin
        m_kind = 2;
        m_base = bus.d_addr & 16'hFFF0;
        m_free = m_g + lat + LW + 1;
      end
    end else if (bus.i_req) begin
      m_kind = 1;
      m_g = n + 1;
      m_base = bus.i_addr & 16'hFFF0;
      m_free = m_g + lat + LW + 1;
    end
    chk("busy", bus.busy, e_busy);
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_wr", bus.mem_wr, e_wr);
    if (e_en) chk("mem_addr", bus.mem_addr, e_addr);
    if (e_wr) chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("i_fill_valid", bus.i_fill_valid, e_ifv);
    chk("d_fill_valid", bus.d_fill_valid, e_dfv);
    chk("i_done", bus.i_done, e_idn);
    chk("d_done", bus.d_done, e_ddn);
    if (e_ifv || e_dfv) begin
      chk("fill_idx", bus.fill_idx, idx);
      chk("fill_data", bus.fill_data, e_fd);
    end
  endtask

  // requester agents: hold req until done, drop, re-raise after a gap
  int          i_cnt = 0, d_cnt = 0;
  int          i_low = 100, d_low = 100;
  int          i_gap = 1, d_gap = 1;
  bit          i_rnd = 0, d_rnd = 0;
  bit          i_sd = 0, d_sd = 0;
  logic [15:0] i_nx = '0, d_nx = '0, d_wdnx = '0;
  logic        d_wrnx = 0;

  task automatic agent_drive();
    if (bus.i_req && i_sd) begin
      bus.i_req = 0;
      i_low = 1;
      if (i_rnd) i_gap = $urandom_range(1, 3);
    end else if (!bus.i_req) begin
      if (i_cnt != 0 && i_low >= i_gap &&
          (!i_rnd || $urandom_range(0, 3) == 0)) begin
        bus.i_req = 1;
        bus.i_addr = i_rnd ? 16'($urandom) : i_nx;
        if (i_cnt > 0) i_cnt--;
      end else begin
        i_low++;
      end
    end
    if (bus.d_req && d_sd) begin
      bus.d_req = 0;
      d_low = 1;
      if (d_rnd) d_gap = $urandom_range(1, 3);
    end else if (!bus.d_req) begin
      if (d_cnt != 0 && d_low >= d_gap &&
          (!d_rnd || $urandom_range(0, 3) == 0)) begin
        bus.d_req = 1;
        bus.d_addr = d_rnd ? 16'($urandom) : d_nx;
        bus.d_wr = d_rnd ? 1'($urandom_range(0, 1)) : d_wrnx;
        bus.d_wdata = d_rnd ? 16'($urandom) : d_wdnx;
        if (d_cnt > 0) d_cnt--;
      end else begin
        d_low++;
      end
    end
  endtask

  // per-window event tallies
  int ifv_cnt, dfv_cnt, idn_cnt, ddn_cnt, busy_cnt, ewr_cnt, rv_cnt;
  int first_en, idn_cyc, ddn_cyc, en_start;
  logic prev_en = 0;
  logic [15:0] wa, wd, fa_first, fa_last;
  bit fa_set;

  task automatic clear_tally();
    ifv_cnt = 0; dfv_cnt = 0; idn_cnt = 0; ddn_cnt = 0;
    busy_cnt = 0; ewr_cnt = 0; rv_cnt = 0;
    first_en = -1; idn_cyc = -1; ddn_cyc = -1; en_start = -1;
    wa = '0; wd = '0; fa_first = '0; fa_last = '0; fa_set = 0;
  endtask

  task automatic tally();
    if (bus.i_fill_valid) ifv_cnt++;
    if (bus.d_fill_valid) dfv_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.mem_rvalid) rv_cnt++;
    if (bus.i_done) begin
      idn_cnt++;
      if (idn_cyc < 0) idn_cyc = n;
    end
    if (bus.d_done) begin
      ddn_cnt++;
      if (ddn_cyc < 0) ddn_cyc = n;
    end
    if (bus.mem_en && first_en < 0) first_en = n;
    if (bus.mem_en && !prev_en) en_start = n;
    if (bus.mem_en && bus.mem_wr) begin
      ewr_cnt++;
      wa = bus.mem_addr;
      wd = bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_wr) begin
      if (!fa_set) fa_first = bus.mem_addr;
      fa_set = 1;
      fa_last = bus.mem_addr;
    end
    prev_en = bus.mem_en;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    #1 agent_drive();
    @(negedge clk);
    model_check();
    tally();
    i_sd = bus.i_done;
    d_sd = bus.d_done;
  endtask

  task automatic run(input int cyc);
    for (int k = 0; k < cyc; k++) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_en"}, bus.mem_en, 0);
    chk({tag, "_wr"}, bus.mem_wr, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_ifv"}, bus.i_fill_valid, 0);
    chk({tag, "_dfv"}, bus.d_fill_valid, 0);
    chk({tag, "_idn"}, bus.i_done, 0);
    chk({tag, "_ddn"}, bus.d_done, 0);
    chk({tag, "_fdata"}, bus.fill_data, 0);
    chk({tag, "_fidx"}, bus.fill_idx, 0);
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_wr = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    clear_tally();

    // single I fill
    i_nx = 16'h1234; i_cnt = 1;
    run(22);
    chk("ifill_words", ifv_cnt, 8);
    chk("ifill_dfv", dfv_cnt, 0);
    chk("ifill_done", idn_cnt, 1);
    chk("ifill_lat", idn_cyc + 1 - first_en, 12);
    chk("ifill_first", fa_first, 16'h1230);
    chk("ifill_last", fa_last, 16'h123E);

    // simultaneous requests: D first, then I with a late address
    clear_tally();
    i_nx = 16'h4A50; i_cnt = 1;
    d_nx = 16'h7788; d_wrnx = 0; d_cnt = 1;
    run(5);
    bus.i_addr = 16'h9ABC;
    run(40);
    chk("prio_ddone", ddn_cnt, 1);
    chk("prio_idone", idn_cnt, 1);
    chk("prio_order", ddn_cyc < idn_cyc, 1);
    chk("prio_ilast", fa_last, 16'h9ABE);

    // D single-word write
    clear_tally();
    d_nx = 16'h0041; d_wrnx = 1; d_wdnx = 16'hBEEF; d_cnt = 1;
    run(8);
    chk("wr_cycles", ewr_cnt, 1);
    chk("wr_addr", wa, 16'h0040);
    chk("wr_data", wd, 16'hBEEF);
    chk("wr_done", ddn_cnt, 1);
    chk("wr_busy", busy_cnt, 2);

    // D fill at the top of the address space
    clear_tally();
    d_nx = 16'hFFF8; d_wrnx = 0; d_cnt = 1;
    run(22);
    chk("wrap_first", fa_first, 16'hFFF0);
    chk("wrap_last", fa_last, 16'hFFFE);
    chk("wrap_done", ddn_cnt, 1);

    // back-to-back I fills with a one-cycle req drop
    clear_tally();
    i_nx = 16'h0100; i_gap = 1; i_cnt = 2;
    run(50);
    chk("b2b_done", idn_cnt, 2);
    chk("b2b_regrant", en_start - idn_cyc, 3);

    // reset in the middle of a fill
    clear_tally();
    i_nx = 16'h2468; i_cnt = 1;
    for (int k = 0; k < 40 && ifv_cnt < 3; k++) step();
    chk("rst_reach", ifv_cnt, 3);
    #2 rst_n = 0;
    bus.i_req = 0; i_cnt = 0; i_low = 100; i_gap = 1;
    #1 chk_zero("rst_mid");
    @(posedge clk);
    n++;
    #1 chk_zero("rst_hold");
    @(negedge clk);
    #2 rst_n = 1;
    m_free = 0; i_sd = 0; d_sd = 0;
    clear_tally();
    run(10);
    chk("rst_late_rv", rv_cnt != 0, 1);
    chk("rst_late_ifv", ifv_cnt, 0);
    clear_tally();
    i_nx = 16'h1358; i_cnt = 1;
    run(20);
    chk("rst_refill", ifv_cnt, 8);
    chk("rst_redone", idn_cnt, 1);

    // random traffic at several latencies
    for (int p = 0; p < 3; p++) begin
      i_cnt = 0; d_cnt = 0;
      run(40);
      lat = (p == 0) ? 1 : (p == 1) ? 3 : 6;
      i_rnd = 1; d_rnd = 1; i_cnt = -1; d_cnt = -1;
      clear_tally();
      run(400);
      chk("rand_idone", idn_cnt != 0, 1);
      chk("rand_ddone", ddn_cnt != 0, 1);
    end
    i_cnt = 0; d_cnt = 0;
    run(40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
